rf_write_ctrl: RTL and testbench



---
 rtl/rf_pkg.sv | 11 +
 rtl/rf_wq_fifo.sv | 57 +++++
 rtl/rf_write_ctrl.sv | 136 +++++++++++++
 tb/tb_rf_write_ctrl.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/rf_pkg.sv
// Shared register-file types and constants for the write-side controller.
package rf_pkg;
  localparam int unsigned RF_ADDR_W = 5;
  localparam int unsigned RF_DATA_W = 32;
  localparam int unsigned RF_NREGS  = 32;

  typedef struct packed {
    logic [RF_ADDR_W-1:0] addr;
    logic [RF_DATA_W-1:0] data;
  } rf_wr_t;
endpackage

// File: rtl/rf_wq_fifo.sv
// Dual-push, single-pop circular write queue; exposes entries in age order (0 = head).
module rf_wq_fifo
  import rf_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  input  logic                   i_push_a,
  input  rf_wr_t                 i_wr_a,
  input  logic                   i_push_b,
  input  rf_wr_t                 i_wr_b,
  input  logic                   i_pop,
  output rf_wr_t                 o_head,
  output logic [$clog2(DEPTH):0] o_count,
  output rf_wr_t [DEPTH-1:0]     o_ord,
  output logic [DEPTH-1:0]       o_ord_vld
);
  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  rf_wr_t             mem [DEPTH];
  logic [PTR_W-1:0]   rd_ptr;
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   wr_ptr_b;
  logic [CNT_W-1:0]   count;

  // The second push lands after the first, or at wr_ptr when only b pushes.
  assign wr_ptr_b = wr_ptr + PTR_W'(i_push_a);

  always_ff @(posedge i_clk) begin
    if (i_push_a) mem[wr_ptr]   <= i_wr_a;
    if (i_push_b) mem[wr_ptr_b] <= i_wr_b;
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      rd_ptr <= rd_ptr + PTR_W'(i_pop);
      wr_ptr <= wr_ptr + PTR_W'(i_push_a) + PTR_W'(i_push_b);
      count  <= count + CNT_W'(i_push_a) + CNT_W'(i_push_b) - CNT_W'(i_pop);
    end
  end

  assign o_head  = mem[rd_ptr];
  assign o_count = count;

  always_comb begin
    for (int unsigned i = 0; i < DEPTH; i++) begin
      o_ord[i]     = mem[rd_ptr + PTR_W'(i)];
      o_ord_vld[i] = (CNT_W'(i) < count);
    end
  end
endmodule

// File: rtl/rf_write_ctrl.sv
// Register-file write controller: x0 filtering, ordered queue, registered write port,
// pending mask and sticky overflow. Define RF_BYPASS_EN to add the read-bypass ports.
module rf_write_ctrl
  import rf_pkg::*;
#(
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 5
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_ld_valid,
  input  logic [ADDR_W-1:0] i_ld_waddr,
  input  logic [DATA_W-1:0] i_ld_wdata,
  input  logic              i_alu_valid,
  input  logic [ADDR_W-1:0] i_alu_waddr,
  input  logic [DATA_W-1:0] i_alu_wdata,
  output logic              o_ready,
  output logic              o_rf_we,
  output logic [ADDR_W-1:0] o_rf_waddr,
  output logic [DATA_W-1:0] o_rf_wdata,
  output logic [31:0]       o_pending,
  output logic              o_ovf
`ifdef RF_BYPASS_EN
  ,
  input  logic [ADDR_W-1:0] i_raddr1,
  input  logic [ADDR_W-1:0] i_raddr2,
  output logic              o_byp1_hit,
  output logic              o_byp2_hit,
  output logic [DATA_W-1:0] o_byp1_data,
  output logic [DATA_W-1:0] o_byp2_data
`endif
);
  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

  logic               req_ld;
  logic               req_alu;
  logic               push_ld;
  logic               push_alu;
  logic               pop;
  rf_wr_t             wr_ld;
  rf_wr_t             wr_alu;
  rf_wr_t             head;
  logic [CNT_W-1:0]   count;
  rf_wr_t [DEPTH-1:0] ord;
  logic [DEPTH-1:0]   ord_vld;

  assign req_ld   = i_ld_valid  && (i_ld_waddr  != '0);
  assign req_alu  = i_alu_valid && (i_alu_waddr != '0);
  assign o_ready  = (count <= CNT_W'(DEPTH - 2));
  assign push_ld  = req_ld  && o_ready;
  assign push_alu = req_alu && o_ready;
  assign pop      = (count != '0);

  assign wr_ld  = '{addr: RF_ADDR_W'(i_ld_waddr),  data: RF_DATA_W'(i_ld_wdata)};
  assign wr_alu = '{addr: RF_ADDR_W'(i_alu_waddr), data: RF_DATA_W'(i_alu_wdata)};

  rf_wq_fifo #(.DEPTH(DEPTH)) u_fifo (
    .i_clk     (i_clk),
    .i_rst_n   (i_rst_n),
    .i_push_a  (push_ld),
    .i_wr_a    (wr_ld),
    .i_push_b  (push_alu),
    .i_wr_b    (wr_alu),
    .i_pop     (pop),
    .o_head    (head),
    .o_count   (count),
    .o_ord     (ord),
    .o_ord_vld (ord_vld)
  );

  // x0 requests never count as overflow since they would not have used a slot.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      o_rf_we    <= 1'b0;
      o_rf_waddr <= '0;
      o_rf_wdata <= '0;
      o_ovf      <= 1'b0;
    end else begin
      o_rf_we <= pop;
      if (pop) begin
        o_rf_waddr <= ADDR_W'(head.addr);
        o_rf_wdata <= DATA_W'(head.data);
      end
      if (!o_ready && (req_ld || req_alu)) o_ovf <= 1'b1;
    end
  end

  always_comb begin
    o_pending = '0;
    if (o_rf_we) o_pending[o_rf_waddr] = 1'b1;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (ord_vld[i]) o_pending[ord[i].addr] = 1'b1;
    end
  end

`ifdef RF_BYPASS_EN
  typedef struct packed {
    logic              hit;
    logic [DATA_W-1:0] data;
  } byp_t;

  // Scan oldest to youngest so the youngest match wins; output stage is oldest.
  function automatic byp_t byp_lookup(
    input logic [ADDR_W-1:0] ra,
    input logic              we,
    input logic [ADDR_W-1:0] wa,
    input logic [DATA_W-1:0] wd,
    input rf_wr_t [DEPTH-1:0] q,
    input logic [DEPTH-1:0]  qv
  );
    byp_t r;
    r = '0;
    if (ra != '0) begin
      if (we && (wa == ra)) r = '{hit: 1'b1, data: wd};
      for (int unsigned i = 0; i < DEPTH; i++) begin
        if (qv[i] && (ADDR_W'(q[i].addr) == ra)) r = '{hit: 1'b1, data: DATA_W'(q[i].data)};
      end
    end
    return r;
  endfunction

  byp_t byp1;
  byp_t byp2;

  always_comb begin
    byp1 = byp_lookup(i_raddr1, o_rf_we, o_rf_waddr, o_rf_wdata, ord, ord_vld);
    byp2 = byp_lookup(i_raddr2, o_rf_we, o_rf_waddr, o_rf_wdata, ord, ord_vld);
  end

  assign o_byp1_hit  = byp1.hit;
  assign o_byp1_data = byp1.data;
  assign o_byp2_hit  = byp2.hit;
  assign o_byp2_data = byp2.data;
`endif
endmodule

// File: tb/tb_rf_write_ctrl.sv
// Scoreboard bench for rf_write_ctrl; bypass checks compile in with RF_BYPASS_EN.
module tb_rf_write_ctrl;
  localparam int unsigned DEPTH = 4;

  logic        i_clk = 1'b0;
  logic        i_rst_n;
  logic        i_ld_valid, i_alu_valid;
  logic [4:0]  i_ld_waddr, i_alu_waddr;
  logic [31:0] i_ld_wdata, i_alu_wdata;
  logic        o_ready, o_rf_we, o_ovf;
  logic [4:0]  o_rf_waddr;
  logic [31:0] o_rf_wdata, o_pending;
`ifdef RF_BYPASS_EN
  logic [4:0]  i_raddr1 = '0, i_raddr2 = '0;
  logic        o_byp1_hit, o_byp2_hit;
  logic [31:0] o_byp1_data, o_byp2_data;
`endif

  int n_checks = 0;
  int n_errors = 0;
  int m_cnt    = 0;
  logic m_ovf  = 1'b0;
  logic [36:0] exp_q[$];

  always #5 i_clk = ~i_clk;

  rf_write_ctrl #(.DEPTH(DEPTH), .DATA_W(32), .ADDR_W(5)) dut (
    .i_clk       (i_clk),
    .i_rst_n     (i_rst_n),
    .i_ld_valid  (i_ld_valid),
    .i_ld_waddr  (i_ld_waddr),
    .i_ld_wdata  (i_ld_wdata),
    .i_alu_valid (i_alu_valid),
    .i_alu_waddr (i_alu_waddr),
    .i_alu_wdata (i_alu_wdata),
    .o_ready     (o_ready),
    .o_rf_we     (o_rf_we),
    .o_rf_waddr  (o_rf_waddr),
    .o_rf_wdata  (o_rf_wdata),
    .o_pending   (o_pending),
    .o_ovf       (o_ovf)
`ifdef RF_BYPASS_EN
    ,
    .i_raddr1    (i_raddr1),
    .i_raddr2    (i_raddr2),
    .o_byp1_hit  (o_byp1_hit),
    .o_byp2_hit  (o_byp2_hit),
    .o_byp1_data (o_byp1_data),
    .o_byp2_data (o_byp2_data)
`endif
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // One clock cycle of stimulus, driven just after a negedge; the model tracks count and ovf.
  task automatic cycle(input logic lv, input logic [4:0] la, input logic [31:0] ldat,
                       input logic av, input logic [4:0] aa, input logic [31:0] adat);
    int   pushes;
    logic exp_ready;
    i_ld_valid  = lv;  i_ld_waddr  = la; i_ld_wdata  = ldat;
    i_alu_valid = av;  i_alu_waddr = aa; i_alu_wdata = adat;
    exp_ready = (m_cnt <= int'(DEPTH) - 2);
    check("ready", 64'(o_ready), 64'(exp_ready));
    pushes = 0;
    if (exp_ready) begin
      if (lv && la != 5'd0) begin exp_q.push_back({la, ldat}); pushes++; end
      if (av && aa != 5'd0) begin exp_q.push_back({aa, adat}); pushes++; end
    end else if ((lv && la != 5'd0) || (av && aa != 5'd0)) begin
      m_ovf = 1'b1;
    end
    @(negedge i_clk);
    m_cnt = m_cnt + pushes - ((m_cnt > 0) ? 1 : 0);
    i_ld_valid = 1'b0; i_alu_valid = 1'b0;
    check("ovf", 64'(o_ovf), 64'(m_ovf));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
  endtask

  always @(negedge i_clk) begin : mon
    logic [36:0] e;
    if (o_rf_we === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("spurious_we", 64'(o_rf_we), 64'h0);
      end else begin
        e = exp_q.pop_front();
        check("waddr", 64'(o_rf_waddr), 64'(e[36:32]));
        check("wdata", 64'(o_rf_wdata), 64'(e[31:0]));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    i_rst_n = 1'b0;
    i_ld_valid = 1'b0; i_ld_waddr = '0; i_ld_wdata = '0;
    i_alu_valid = 1'b0; i_alu_waddr = '0; i_alu_wdata = '0;
    repeat (2) @(negedge i_clk);
    check("rst_we",      64'(o_rf_we),    64'h0);
    check("rst_waddr",   64'(o_rf_waddr), 64'h0);
    check("rst_wdata",   64'(o_rf_wdata), 64'h0);
    check("rst_pending", 64'(o_pending),  64'h0);
    check("rst_ovf",     64'(o_ovf),      64'h0);
    check("rst_ready",   64'(o_ready),    64'h1);
    i_rst_n = 1'b1;

    // Single ALU write: visible on the port one cycle after acceptance.
    cycle(1'b0, 5'd0, 32'd0, 1'b1, 5'd5, 32'hDEADBEEF);
    check("t1_pend_q", 64'(o_pending), 64'h20);
    idle(1);
    check("t1_we",     64'(o_rf_we),   64'h1);
    check("t1_pend_o", 64'(o_pending), 64'h20);
    idle(1);
    check("t1_we_off", 64'(o_rf_we),   64'h0);
    check("t1_pend_0", 64'(o_pending), 64'h0);

    // Same-cycle writes to one register: load first, ALU second.
    cycle(1'b1, 5'd7, 32'h11, 1'b1, 5'd7, 32'h22);
    check("t2_pend_a", 64'(o_pending), 64'h80);
    idle(1);
    check("t2_pend_b", 64'(o_pending), 64'h80);
    idle(1);
    check("t2_pend_c", 64'(o_pending), 64'h80);
    idle(1);
    check("t2_pend_0", 64'(o_pending), 64'h0);

    // x0 write is dropped.
    cycle(1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 32'hFFFF);
    check("t3_pend", 64'(o_pending), 64'h0);
    idle(1);
    check("t3_we",   64'(o_rf_we),   64'h0);
    check("t3_pend2", 64'(o_pending), 64'h0);

    // Fill: third dual push meets o_ready=0 and is lost.
    cycle(1'b1, 5'd1, 32'hA1, 1'b1, 5'd2, 32'hA2);
    cycle(1'b1, 5'd3, 32'hA3, 1'b1, 5'd4, 32'hA4);
    cycle(1'b1, 5'd5, 32'hA5, 1'b1, 5'd6, 32'hA6);
    check("t4_ovf", 64'(o_ovf), 64'h1);
    idle(6);
    check("t4_drained", 64'(exp_q.size()), 64'h0);

`ifdef RF_BYPASS_EN
    i_raddr1 = 5'd9; i_raddr2 = 5'd0;
    cycle(1'b1, 5'd9, 32'hA, 1'b1, 5'd9, 32'hB);
    check("byp1_hit",  64'(o_byp1_hit),  64'h1);
    check("byp1_data", 64'(o_byp1_data), 64'hB);
    check("byp2_hit",  64'(o_byp2_hit),  64'h0);
    idle(1);
    check("byp1_data_o", 64'(o_byp1_data), 64'hB);
    idle(3);
    check("byp1_gone", 64'(o_byp1_hit), 64'h0);
    i_raddr1 = 5'd0;
`endif

    // Reset with 3 entries queued: none may reach the write port.
    cycle(1'b1, 5'd10, 32'hC1, 1'b1, 5'd11, 32'hC2);
    cycle(1'b1, 5'd12, 32'hC3, 1'b1, 5'd13, 32'hC4);
    i_rst_n = 1'b0;
    @(negedge i_clk);
    check("t5_we",      64'(o_rf_we),   64'h0);
    check("t5_pending", 64'(o_pending), 64'h0);
    check("t5_ready",   64'(o_ready),   64'h1);
    check("t5_ovf",     64'(o_ovf),     64'h0);
    exp_q.delete();
    m_cnt = 0; m_ovf = 1'b0;
    i_rst_n = 1'b1;
    idle(6);

    // Random traffic against the scoreboard.
    for (int i = 0; i < 60; i++) begin
      cycle(1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), $urandom,
            1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), $urandom);
    end
    idle(8);
    check("final_drained", 64'(exp_q.size()), 64'h0);
    check("final_pending", 64'(o_pending),    64'h0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
